mem_access_stage: RTL and testbench

//  MEM stage of the 5-stage pipeline. It sits directly downstream of the EX/MEM register.

---
 rtl/mem_access_stage.sv | 166 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM stage: turns word loads/stores from EX/MEM into a req/ack data-memory
// transaction, stalls upstream while it is in flight, and retires every
// non-bubble instruction through registered wb_* outputs.
module mem_access_stage #(
    parameter logic [4:0]  LOAD_OP  = 5'b01000,
    parameter logic [4:0]  STORE_OP = 5'b01001,
    parameter logic [4:0]  NOP_OP   = 5'b00000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  OpCode,
    input  logic [31:0] AluResult,
    input  logic [31:0] RdOut,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_valid,
    output logic [4:0]  wb_opcode,
    output logic [31:0] wb_result,
    output logic        mem_err
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    // Last WAIT count at which a missing ack turns into a timeout.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [4:0]    op_q, op_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wb_valid_q, wb_valid_d;
    logic [4:0]    wb_opcode_q, wb_opcode_d;
    logic [31:0]   wb_result_q, wb_result_d;
    logic          mem_err_q, mem_err_d;
    logic          is_mem_s;

    assign is_mem_s = (OpCode == LOAD_OP) || (OpCode == STORE_OP);

    // Upstream holds while a memory op is being accepted or is in flight.
    assign stall = (state_q == ST_WAIT) || ((state_q == ST_IDLE) && is_mem_s);

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_opcode = wb_opcode_q;
    assign wb_result = wb_result_q;
    assign mem_err   = mem_err_q;

    // Next-state, memory-port and retirement logic.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cnt_d       = cnt_q;
        wb_valid_d  = 1'b0;
        wb_opcode_d = wb_opcode_q;
        wb_result_d = wb_result_q;
        mem_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_mem_s) begin
                    if (AluResult[1:0] != 2'b00) begin
                        // Misaligned: never touch memory, retire with an error.
                        state_d     = ST_DONE;
                        wb_valid_d  = 1'b1;
                        wb_opcode_d = OpCode;
                        wb_result_d = AluResult;
                        mem_err_d   = 1'b1;
                    end else begin
                        state_d     = ST_WAIT;
                        op_d        = OpCode;
                        mem_req_d   = 1'b1;
                        mem_we_d    = (OpCode == STORE_OP);
                        mem_addr_d  = {AluResult[31:2], 2'b00};
                        mem_wdata_d = RdOut;
                        cnt_d       = {CW{1'b0}};
                    end
                end else begin
                    // Plain ALU result passes straight through; bubbles do not retire.
                    wb_valid_d  = (OpCode != NOP_OP);
                    wb_opcode_d = OpCode;
                    wb_result_d = AluResult;
                end
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    state_d     = ST_DONE;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    wb_valid_d  = 1'b1;
                    wb_opcode_d = op_q;
                    wb_result_d = (op_q == LOAD_OP) ? mem_rdata : mem_addr_q;
                end else if (cnt_q == CNT_LAST) begin
                    // Give up on the memory: retire with a zero result and flag it.
                    state_d     = ST_DONE;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    wb_valid_d  = 1'b1;
                    wb_opcode_d = op_q;
                    wb_result_d = 32'h0000_0000;
                    mem_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                // Upstream advances at this edge; the stale input is ignored.
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; async reset abandons any outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= 5'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            cnt_q       <= {CW{1'b0}};
            wb_valid_q  <= 1'b0;
            wb_opcode_q <= 5'd0;
            wb_result_q <= 32'h0000_0000;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cnt_q       <= cnt_d;
            wb_valid_q  <= wb_valid_d;
            wb_opcode_q <= wb_opcode_d;
            wb_result_q <= wb_result_d;
            mem_err_q   <= mem_err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomised scoreboard bench for mem_access_stage: a driver acts as the
// upstream pipeline, a responder acts as data memory, a monitor checks retirements.
module tb_mem_access_stage;

    localparam logic [4:0] LOAD_OP  = 5'b01000;
    localparam logic [4:0] STORE_OP = 5'b01001;
    localparam logic [4:0] NOP_OP   = 5'b00000;
    localparam int         TO       = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  OpCode;
    logic [31:0] AluResult, RdOut;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        wb_valid, mem_err;
    logic [4:0]  wb_opcode;
    logic [31:0] wb_result;

    typedef struct { logic [4:0] op; logic [31:0] res; logic err; } exp_t;
    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; int lat; } req_t;

    exp_t        exp_q[$];
    req_t        req_q[$];
    logic [31:0] ref_mem [64];
    logic [31:0] dev_mem [64];
    int          checks = 0;
    int          errors = 0;
    bit          en = 1'b0;
    logic        man_ack = 1'b0;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .AluResult(AluResult), .RdOut(RdOut),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_valid(wb_valid), .wb_opcode(wb_opcode), .wb_result(wb_result), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Upstream model: present one instruction, predict its outcome, hold it while stalled.
    task automatic issue(input logic [4:0] op, input logic [31:0] alu,
                         input logic [31:0] rd, input int lat);
        exp_t e;
        req_t r;
        int   exp_stall;
        int   n;
        logic timed_out;
        @(negedge clk);
        OpCode = op; AluResult = alu; RdOut = rd;
        if (op != LOAD_OP && op != STORE_OP) begin
            exp_stall = 0;
            if (op != NOP_OP) begin
                e.op = op; e.res = alu; e.err = 1'b0; exp_q.push_back(e);
            end
        end else if (alu[1:0] != 2'b00) begin
            exp_stall = 1;
            e.op = op; e.res = alu; e.err = 1'b1; exp_q.push_back(e);
        end else begin
            timed_out = (lat > TO);
            exp_stall = 1 + (timed_out ? TO : lat);
            r.addr = alu; r.we = (op == STORE_OP); r.wdata = rd; r.lat = lat;
            req_q.push_back(r);
            e.op = op; e.err = timed_out;
            if (timed_out)           e.res = 32'h0;
            else if (op == LOAD_OP)  e.res = ref_mem[alu[7:2]];
            else                     e.res = alu;
            if (op == STORE_OP && !timed_out) ref_mem[alu[7:2]] = rd;
            exp_q.push_back(e);
        end
        #1;
        n = 0;
        while (stall && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("stall_cycles", n, exp_stall);
    endtask

    // Memory responder: acks in the lat-th request cycle, checks request fields.
    initial begin
        bit   active = 1'b0;
        int   cyc = 0;
        int   len;
        req_t cur;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!en) begin
                mem_ack = man_ack;
                active = 1'b0;
                continue;
            end
            if (mem_req) begin
                if (!active) begin
                    active = 1'b1;
                    cyc = 0;
                    if (req_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL mem_req_unexpected actual=1 required=0 at %0t", $time);
                        cur.addr = mem_addr; cur.we = mem_we; cur.wdata = mem_wdata; cur.lat = 1000;
                    end else begin
                        cur = req_q.pop_front();
                    end
                end
                cyc++;
                chk("mem_addr", mem_addr, cur.addr);
                chk("mem_we", {31'd0, mem_we}, {31'd0, cur.we});
                if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
                if (cyc == cur.lat) begin
                    mem_ack = 1'b1;
                    mem_rdata = dev_mem[cur.addr[7:2]];
                    if (cur.we) dev_mem[cur.addr[7:2]] = cur.wdata;
                end else begin
                    mem_ack = 1'b0;
                    mem_rdata = $urandom;
                end
            end else begin
                if (active) begin
                    len = (cur.lat > TO) ? TO : cur.lat;
                    chk("mem_req_cycles", cyc, len);
                    active = 1'b0;
                end
                // Stray acks outside a request must be ignored.
                mem_ack = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    // Monitor: every retirement is popped from the scoreboard and compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (en) begin
                if (wb_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL wb_unexpected actual_op=%h actual_res=%h required=none", wb_opcode, wb_result);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wb_opcode", {27'd0, wb_opcode}, {27'd0, e.op});
                        chk("wb_result", wb_result, e.res);
                        chk("mem_err", {31'd0, mem_err}, {31'd0, e.err});
                    end
                end else begin
                    chk("mem_err_idle", {31'd0, mem_err}, 32'd0);
                end
            end
        end
    end

    // Global bound on run time.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [4:0]  op;
        int          lat;
        int          sel;
        rst_n = 1'b0; OpCode = NOP_OP; AluResult = 32'h0; RdOut = 32'h0;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = $urandom;
            dev_mem[i] = ref_mem[i];
        end
        ref_mem[16] = 32'hCAFE_BABE;
        dev_mem[16] = 32'hCAFE_BABE;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_opcode", {27'd0, wb_opcode}, 32'd0);
        chk("rst_wb_result", wb_result, 32'd0);
        chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of WAIT; a late ack must be ignored.
        @(negedge clk);
        OpCode = LOAD_OP; AluResult = 32'h80;
        @(negedge clk);
        chk("midwait_req_up", {31'd0, mem_req}, 32'd1);
        OpCode = NOP_OP;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midwait_rst_req", {31'd0, mem_req}, 32'd0);
        chk("midwait_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("midwait_rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        man_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("late_ack_req", {31'd0, mem_req}, 32'd0);
            chk("late_ack_wb_valid", {31'd0, wb_valid}, 32'd0);
            chk("late_ack_stall", {31'd0, stall}, 32'd0);
        end
        man_ack = 1'b0;
        @(negedge clk);
        en = 1'b1;

        // Directed cases.
        issue(5'h02, 32'd10, 32'd0, 1);
        issue(5'h03, 32'd20, 32'd0, 1);
        issue(NOP_OP, 32'd99, 32'd0, 1);
        issue(5'h02, 32'd30, 32'd0, 1);
        issue(LOAD_OP, 32'h40, 32'd0, 3);
        issue(STORE_OP, 32'h44, 32'h1234, 1);
        issue(LOAD_OP, 32'h44, 32'd0, 1);
        issue(LOAD_OP, 32'h41, 32'd0, 1);
        issue(NOP_OP, 32'd0, 32'd0, 1);
        issue(LOAD_OP, 32'h48, 32'd0, TO + 1);
        issue(LOAD_OP, 32'h4C, 32'd0, TO);
        issue(STORE_OP, 32'h50, 32'hDEAD_0001, TO + 2);
        issue(LOAD_OP, 32'h50, 32'd0, 2);

        // Randomised stream.
        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 99);
            lat = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 1, TO + 2) : $urandom_range(1, 4);
            a = $urandom_range(0, 63) * 4;
            if ($urandom_range(0, 6) == 0) a = a + $urandom_range(1, 3);
            if (sel < 30) begin
                op = 5'($urandom_range(0, 31));
                if (op == LOAD_OP || op == STORE_OP) op = NOP_OP;
                issue(op, $urandom, $urandom, lat);
            end else if (sel < 65) begin
                issue(LOAD_OP, a, $urandom, lat);
            end else begin
                issue(STORE_OP, a, $urandom, lat);
            end
        end

        // Drain and confirm nothing was left outstanding.
        issue(NOP_OP, 32'd0, 32'd0, 1);
        repeat (4) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 32'd0);
        chk("req_q_empty", req_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
